// File: rtl/mfp_ahb_gpio_arbiter.sv
// Two-requester AHB-Lite master front-end for the GPIO slave port.
// Each accepted request becomes one zero-wait single transfer
// (address phase, data phase, then a one-cycle done pulse to the owner).
// Contention is resolved round-robin; one transfer is in flight at a time.
module mfp_ahb_gpio_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [1:0]        gnt,
  output logic              M_HSEL,
  output logic [ADDR_W-1:0] M_HADDR,
  output logic [1:0]        M_HTRANS,
  output logic              M_HWRITE,
  output logic [DATA_W-1:0] M_HWDATA,
  input  logic [DATA_W-1:0] M_HRDATA
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q;
  logic                last_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                any_req;
  logic                winner;

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    any_req = req0 | req1;
    winner  = (req0 && req1) ? ~last_q : req1;
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch the winner's transfer qualifiers and update the last-grant pointer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      owner_q <= winner;
      last_q  <= winner;
      wr_q    <= winner ? wr1    : wr0;
      addr_q  <= winner ? addr1  : addr0;
      wdata_q <= winner ? wdata1 : wdata0;
    end
  end

  // Capture slave read data into the owner's rdata on the closing edge of the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state_q == DATA && !wr_q) begin
      if (owner_q) rdata1 <= M_HRDATA;
      else         rdata0 <= M_HRDATA;
    end
  end

  // Next-state and bus/handshake outputs decoded from the current state.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    gnt      = '0;
    M_HSEL   = 1'b0;
    M_HTRANS = 2'b00;
    M_HWRITE = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    if (state_q != IDLE) gnt = owner_q ? 2'b10 : 2'b01;
    case (state_q)
      IDLE: if (any_req) state_d = ADDR;
      ADDR: begin
        M_HSEL   = 1'b1;
        M_HTRANS = 2'b10;
        M_HWRITE = wr_q;
        state_d  = DATA;
      end
      DATA: state_d = RESP;
      RESP: begin
        done0   = ~owner_q;
        done1   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address is held through the data phase; write data is the latched value.
  assign M_HADDR  = addr_q;
  assign M_HWDATA = wdata_q;

endmodule

// File: tb/tb_mfp_ahb_gpio_arbiter.sv
// Scoreboard bench for mfp_ahb_gpio_arbiter: requester tasks push expected
// transfers into per-requester queues; a negedge monitor follows the bus and
// checks grants, phases, done pulses and rdata against a round-robin model.
module tb_mfp_ahb_gpio_arbiter;

  typedef struct packed {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
  } txn_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        done0, done1, busy, M_HSEL, M_HWRITE;
  logic [31:0] rdata0, rdata1, M_HWDATA, M_HRDATA;
  logic [1:0]  gnt, M_HTRANS;
  logic [3:0]  M_HADDR;

  int checks = 0;
  int errors = 0;

  // model state
  txn_t        q0[$], q1[$];
  int          last_m = 1;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  int          addr_times[$];
  int          addr_owner[$];
  int          cyc = 0;
  int          done1_cnt = 0;
  logic        sreq0 = 1'b0, sreq1 = 1'b0;

  // slave model
  logic [31:0] slave_rd = '0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_val = '0;
  assign M_HRDATA = slave_rd;

  mfp_ahb_gpio_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .busy(busy), .gnt(gnt), .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
    .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  always @(posedge HCLK) begin
    cyc   <= cyc + 1;
    sreq0 <= req0;
    sreq1 <= req1;
    if (M_HSEL && M_HTRANS == 2'b10 && !M_HWRITE)
      slave_rd <= use_fixed ? fixed_val :
                  ((M_HADDR == 4'h1 || M_HADDR == 4'h2) ? ($urandom | 32'h1) : 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: follows each transfer through ADDR, DATA and RESP.
  initial begin : monitor
    int   phase;
    int   eo;
    txn_t cur;
    logic [31:0] cap_rd;
    phase = 0; eo = 0; cur = '0; cap_rd = '0;
    forever begin
      @(negedge HCLK);
      if (done1) done1_cnt++;
      if (!HRESETn) begin
        phase = 0;
        continue;
      end
      if (M_HTRANS != 2'b00 && M_HTRANS != 2'b10) chk("htrans_legal", {30'd0, M_HTRANS}, 32'd2);
      if (phase != 2) begin
        chk("rdata0_hold", rdata0, exp_rd0);
        chk("rdata1_hold", rdata1, exp_rd1);
      end
      case (phase)
        0: begin
          chk("idle_done", {30'd0, done1, done0}, 32'd0);
          if (!M_HSEL) begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_gnt", {30'd0, gnt}, 32'd0);
          end else begin
            if (sreq0 && sreq1) eo = 1 - last_m;
            else eo = sreq1 ? 1 : 0;
            if (!sreq0 && !sreq1) chk("grant_without_req", 32'd1, 32'd0);
            last_m = eo;
            if ((eo == 0 && q0.size() == 0) || (eo == 1 && q1.size() == 0)) begin
              chk("unexpected_grant", 32'd1, 32'd0);
              cur = '0;
            end else cur = (eo == 0) ? q0[0] : q1[0];
            addr_times.push_back(cyc);
            addr_owner.push_back(eo);
            chk("addr_gnt", {30'd0, gnt}, (eo == 0) ? 32'd1 : 32'd2);
            chk("addr_htrans", {30'd0, M_HTRANS}, 32'd2);
            chk("addr_haddr", {28'd0, M_HADDR}, {28'd0, cur.a});
            chk("addr_hwrite", {31'd0, M_HWRITE}, {31'd0, cur.w});
            chk("addr_busy", {31'd0, busy}, 32'd1);
            phase = 1;
          end
        end
        1: begin
          chk("data_hsel", {31'd0, M_HSEL}, 32'd0);
          chk("data_htrans", {30'd0, M_HTRANS}, 32'd0);
          chk("data_hwrite", {31'd0, M_HWRITE}, 32'd0);
          chk("data_haddr", {28'd0, M_HADDR}, {28'd0, cur.a});
          chk("data_gnt", {30'd0, gnt}, (eo == 0) ? 32'd1 : 32'd2);
          chk("data_done", {30'd0, done1, done0}, 32'd0);
          if (cur.w) chk("data_hwdata", M_HWDATA, cur.d);
          cap_rd = M_HRDATA;
          phase = 2;
        end
        default: begin
          chk("resp_done", {30'd0, done1, done0}, (eo == 0) ? 32'd1 : 32'd2);
          chk("resp_gnt", {30'd0, gnt}, (eo == 0) ? 32'd1 : 32'd2);
          chk("resp_hsel", {31'd0, M_HSEL}, 32'd0);
          if (!cur.w) begin
            if (eo == 0) exp_rd0 = cap_rd;
            else exp_rd1 = cap_rd;
          end
          chk("resp_rdata0", rdata0, exp_rd0);
          chk("resp_rdata1", rdata1, exp_rd1);
          if (eo == 0 && q0.size() > 0) void'(q0.pop_front());
          if (eo == 1 && q1.size() > 0) void'(q1.pop_front());
          phase = 0;
        end
      endcase
    end
  end

  // Issue one transfer; keep=1 leaves req high so the next call follows directly.
  task automatic xfer(input int r, input logic w, input logic [3:0] a, input logic [31:0] d,
                      input bit keep, output int lat);
    txn_t t;
    bit   held;
    bit   dn;
    int   n;
    t.w = w; t.a = a; t.d = d;
    held = (r == 0) ? req0 : req1;
    if (!held) begin
      @(posedge HCLK);
      #1;
    end
    if (r == 0) begin
      wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; q0.push_back(t);
    end else begin
      wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; q1.push_back(t);
    end
    n = 0;
    dn = 1'b0;
    while (!dn && n < 100) begin
      @(negedge HCLK);
      n++;
      dn = (r == 0) ? done0 : done1;
    end
    lat = n;
    if (!dn) chk("done_timeout", 32'd0, 32'd1);
    @(posedge HCLK);
    #1;
    if (!keep) begin
      if (r == 0) req0 = 1'b0;
      else req1 = 1'b0;
    end
  endtask

  task automatic rand_req(input int r, input int n);
    for (int i = 0; i < n; i++) begin
      bit keep;
      int lat;
      keep = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      xfer(r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom, keep, lat);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge HCLK);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_hsel"}, {31'd0, M_HSEL}, 32'd0);
    chk({tag, "_htrans"}, {30'd0, M_HTRANS}, 32'd0);
    chk({tag, "_hwrite"}, {31'd0, M_HWRITE}, 32'd0);
    chk({tag, "_haddr"}, {28'd0, M_HADDR}, 32'd0);
    chk({tag, "_hwdata"}, M_HWDATA, 32'd0);
    chk({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
  endtask

  initial begin : stim
    int lat, base, d1_before;
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);

    // requester 0 write, uncontended
    xfer(0, 1'b1, 4'h0, 32'h0000_A5A5, 1'b0, lat);
    chk("wr0_latency", lat, 32'd4);
    chk("wr0_rdata0", rdata0, 32'd0);

    // requester 1 read with a fixed slave value
    use_fixed = 1'b1; fixed_val = 32'h0000_1234;
    xfer(1, 1'b0, 4'h1, 32'h0, 1'b0, lat);
    use_fixed = 1'b0;
    chk("rd1_latency", lat, 32'd4);
    chk("rd1_rdata1", rdata1, 32'h0000_1234);
    chk("rd1_rdata0", rdata0, 32'd0);

    // req1 pulsed for one cycle during a requester 0 transfer
    d1_before = done1_cnt;
    fork
      xfer(0, 1'b1, 4'h0, 32'h0000_00F0, 1'b0, lat);
      begin
        repeat (3) @(posedge HCLK);
        #1 req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h2;
        @(posedge HCLK);
        #1 req1 = 1'b0;
      end
    join
    repeat (6) @(posedge HCLK);
    chk("pulse_no_done1", done1_cnt, d1_before);

    // back-to-back reads with a one-cycle gap
    base = addr_times.size();
    xfer(0, 1'b0, 4'h1, 32'h0, 1'b0, lat);
    xfer(0, 1'b0, 4'h2, 32'h0, 1'b0, lat);
    if (addr_times.size() == base + 2)
      chk("b2b_spacing", addr_times[base + 1] - addr_times[base], 32'd5);
    else
      chk("b2b_count", addr_times.size() - base, 32'd2);

    // randomized concurrent traffic
    fork
      rand_req(0, 30);
      rand_req(1, 30);
    join
    repeat (4) @(posedge HCLK);

    // reset during the data phase of a write
    @(posedge HCLK);
    #1 wr0 = 1'b1; addr0 = 4'h0; wdata0 = 32'hDEAD_BEEF; req0 = 1'b1;
    q0.push_back('{w: 1'b1, a: 4'h0, d: 32'hDEAD_BEEF});
    @(posedge HCLK);
    @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    req0 = 1'b0;
    q0.delete(); q1.delete();
    last_m = 1; exp_rd0 = '0; exp_rd1 = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);

    // contention after reset, both held: strict alternation starting with requester 0
    base = addr_times.size();
    fork
      for (int i = 0; i < 2; i++) begin
        int l0;
        xfer(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom, (i == 0), l0);
      end
      for (int i = 0; i < 2; i++) begin
        int l1;
        xfer(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom, (i == 0), l1);
      end
    join
    if (addr_times.size() == base + 4) begin
      for (int i = 0; i < 4; i++)
        chk("alt_owner", addr_owner[base + i], (i % 2 == 0) ? 32'd0 : 32'd1);
      for (int i = 1; i < 4; i++)
        chk("alt_spacing", addr_times[base + i] - addr_times[base + i - 1], 32'd4);
    end else
      chk("alt_count", addr_times.size() - base, 32'd4);

    repeat (4) @(posedge HCLK);
    chk("end_q0_empty", q0.size(), 32'd0);
    chk("end_q1_empty", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
